// File: rtl/mem_tile_seq.sv
// Load/store sequencer in front of the tile memory: range/alignment check, strobe timing, OWORD split.
// Latency: 4 cycles to response (7 for OWORD, 1 for faults); reqReady only in IDLE, response held until rspReady.
module mem_tile_seq #(
  parameter int          TILE_BITS = 14,
  parameter logic [47:0] TILE_BASE = 48'h0
) (
  input  logic         clk,
  input  logic         nReset,
  input  logic         reqValid,
  output logic         reqReady,
  input  logic         reqWr,
  input  logic [2:0]   reqMode,
  input  logic [47:0]  reqAddr,
  input  logic [127:0] reqData,
  output logic         rspValid,
  input  logic         rspReady,
  output logic [127:0] rspData,
  output logic         rspFault,
  output logic         opRd,
  output logic         opWr,
  output logic [2:0]   opMode,
  output logic [47:0]  memAddr,
  output logic [63:0]  wrValue,
  input  logic [63:0]  rdValue
);

  localparam logic [2:0] M_NONE  = 3'd0;
  localparam logic [2:0] M_BYTE  = 3'd1;
  localparam logic [2:0] M_WORD  = 3'd2;
  localparam logic [2:0] M_DWORD = 3'd3;
  localparam logic [2:0] M_QWORD = 3'd4;
  localparam logic [2:0] M_OWORD = 3'd5;
  localparam logic [2:0] M_UBYTE = 3'd6;
  localparam logic [2:0] M_UWORD = 3'd7;

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_RESP} state_t;

  state_t      state;
  logic        phase;
  logic        wr_q;
  logic        oword_q;
  logic [47:0] addr_q;
  logic [63:0] data_hi_q;

  logic [4:0]           acc_size;
  logic [TILE_BITS:0]   end_off;
  logic                 base_miss;
  logic                 misalign;
  logic                 req_fault;

  always_comb begin
    acc_size = 5'd0;
    case (reqMode)
      M_BYTE, M_UBYTE: acc_size = 5'd1;
      M_WORD, M_UWORD: acc_size = 5'd2;
      M_DWORD:         acc_size = 5'd4;
      M_QWORD:         acc_size = 5'd8;
      M_OWORD:         acc_size = 5'd16;
      default:         acc_size = 5'd0;
    endcase
  end

  // An end offset of exactly 2^TILE_BITS is rejected too: its word index would
  // be one past the tile and must never wrap back to word 0.
  assign end_off   = {1'b0, reqAddr[TILE_BITS-1:0]} + {{(TILE_BITS-4){1'b0}}, acc_size};
  assign base_miss = reqAddr[47:TILE_BITS] != TILE_BASE[47:TILE_BITS];
  assign misalign  = ((reqMode == M_QWORD) || (reqMode == M_OWORD)) && (reqAddr[1:0] != 2'b00);
  assign req_fault = (reqMode == M_NONE) || base_miss || misalign || end_off[TILE_BITS];

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state     <= S_IDLE;
      phase     <= 1'b0;
      wr_q      <= 1'b0;
      oword_q   <= 1'b0;
      addr_q    <= '0;
      data_hi_q <= '0;
      reqReady  <= 1'b1;
      rspValid  <= 1'b0;
      rspFault  <= 1'b0;
      rspData   <= '0;
      opRd      <= 1'b0;
      opWr      <= 1'b0;
      opMode    <= '0;
      memAddr   <= '0;
      wrValue   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (reqValid) begin
            reqReady  <= 1'b0;
            rspData   <= '0;
            wr_q      <= reqWr;
            oword_q   <= (reqMode == M_OWORD);
            addr_q    <= reqAddr;
            data_hi_q <= reqData[127:64];
            if (req_fault) begin
              rspFault <= 1'b1;
              rspValid <= 1'b1;
              state    <= S_RESP;
            end else begin
              rspFault <= 1'b0;
              phase    <= 1'b0;
              memAddr  <= reqAddr;
              opMode   <= (reqMode == M_OWORD) ? M_QWORD : reqMode;
              wrValue  <= reqData[63:0];
              state    <= S_SETUP;
            end
          end
        end
        S_SETUP: begin
          opRd  <= !wr_q;
          opWr  <= wr_q;
          state <= S_STROBE;
        end
        S_STROBE: begin
          opRd  <= 1'b0;
          opWr  <= 1'b0;
          state <= S_HOLD;
        end
        S_HOLD: begin
          if (!wr_q) begin
            if (phase) rspData[127:64] <= rdValue;
            else       rspData[63:0]   <= rdValue;
          end
          if (oword_q && !phase) begin
            phase   <= 1'b1;
            memAddr <= addr_q + 48'd8;
            wrValue <= data_hi_q;
            state   <= S_SETUP;
          end else begin
            rspValid <= 1'b1;
            state    <= S_RESP;
          end
        end
        S_RESP: begin
          if (rspReady) begin
            rspValid <= 1'b0;
            reqReady <= 1'b1;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_tile_seq.sv
// Directed bench for mem_tile_seq with a byte-array tile model behind the strobes.
module tb_mem_tile_seq;

  logic         clk = 1'b0;
  logic         nReset;
  logic         reqValid, reqReady, reqWr;
  logic [2:0]   reqMode;
  logic [47:0]  reqAddr;
  logic [127:0] reqData;
  logic         rspValid, rspReady, rspFault;
  logic [127:0] rspData;
  logic         opRd, opWr;
  logic [2:0]   opMode;
  logic [47:0]  memAddr;
  logic [63:0]  wrValue, rdValue;

  mem_tile_seq #(.TILE_BITS(14), .TILE_BASE(48'h0)) dut (
    .clk(clk), .nReset(nReset),
    .reqValid(reqValid), .reqReady(reqReady), .reqWr(reqWr), .reqMode(reqMode),
    .reqAddr(reqAddr), .reqData(reqData),
    .rspValid(rspValid), .rspReady(rspReady), .rspData(rspData), .rspFault(rspFault),
    .opRd(opRd), .opWr(opWr), .opMode(opMode), .memAddr(memAddr),
    .wrValue(wrValue), .rdValue(rdValue)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Tile model: 256 bytes, address wraps on memAddr[7:0].
  logic [7:0] tmem [256];
  logic [63:0] tw;
  int wsize;

  always_comb begin
    wsize = 0;
    case (opMode)
      3'd1, 3'd6: wsize = 1;
      3'd2, 3'd7: wsize = 2;
      3'd3:       wsize = 4;
      3'd4:       wsize = 8;
      default:    wsize = 0;
    endcase
  end

  always_comb begin
    tw = '0;
    for (int k = 0; k < 8; k++) tw[8*k +: 8] = tmem[memAddr[7:0] + 8'(k)];
    case (opMode)
      3'd1:    rdValue = {{56{tw[7]}}, tw[7:0]};
      3'd6:    rdValue = {56'b0, tw[7:0]};
      3'd2:    rdValue = {{48{tw[15]}}, tw[15:0]};
      3'd7:    rdValue = {48'b0, tw[15:0]};
      3'd3:    rdValue = {{32{tw[31]}}, tw[31:0]};
      3'd4:    rdValue = tw;
      default: rdValue = '0;
    endcase
  end

  always @(posedge clk) begin
    if (cyc == 0) begin
      for (int i = 0; i < 256; i++) tmem[i] <= 8'h00;
      tmem[16] <= 8'h01;
      tmem[19] <= 8'h80;
    end else if (opWr) begin
      for (int k = 0; k < 8; k++)
        if (k < wsize) tmem[memAddr[7:0] + 8'(k)] <= wrValue[8*k +: 8];
    end
  end

  // Strobe monitor
  int          scnt, rcnt, overlap;
  int          s_cyc  [2];
  logic [47:0] s_addr [2];
  logic [63:0] s_val  [2];
  logic [2:0]  s_mode [2];

  initial overlap = 0;
  always @(negedge clk) begin
    if (opRd && opWr) overlap = overlap + 1;
    if (opRd || opWr) begin
      if (scnt < 2) begin
        s_cyc[scnt]  = cyc;
        s_addr[scnt] = memAddr;
        s_val[scnt]  = wrValue;
        s_mode[scnt] = opMode;
      end
      scnt = scnt + 1;
      if (opRd) rcnt = rcnt + 1;
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic         wr;
    logic [2:0]   mode;
    logic [47:0]  addr;
    logic [127:0] data;
    logic         fault;
    logic [127:0] rdata;
  } vec_t;

  task automatic run(input vec_t v, input int hold, input string nm);
    int acc, n, exp_n, exp_lat;
    bit bad;
    exp_n   = v.fault ? 0 : ((v.mode == 3'd5) ? 2 : 1);
    exp_lat = v.fault ? 0 : ((v.mode == 3'd5) ? 6 : 3);
    rspReady = (hold == 0);
    n = 0;
    while (!reqReady && n < 20) begin @(negedge clk); n++; end
    chk({nm, " reqReady idle"}, 128'(reqReady), 128'(1));
    scnt = 0; rcnt = 0;
    reqValid = 1'b1; reqWr = v.wr; reqMode = v.mode; reqAddr = v.addr; reqData = v.data;
    @(negedge clk);
    reqValid = 1'b0;
    acc = cyc;
    chk({nm, " reqReady after accept"}, 128'(reqReady), 128'(0));
    n = 0;
    while (!rspValid && n < 20) begin @(negedge clk); n++; end
    chk({nm, " rsp latency"}, 128'(n), 128'(exp_lat));
    chk({nm, " rspFault"}, 128'(rspFault), 128'(v.fault));
    chk({nm, " rspData"}, rspData, v.rdata);
    chk({nm, " reqReady in resp"}, 128'(reqReady), 128'(0));
    chk({nm, " strobe count"}, 128'(scnt), 128'(exp_n));
    chk({nm, " read strobes"}, 128'(rcnt), 128'(v.wr ? 0 : exp_n));
    if (exp_n > 0) begin
      chk({nm, " strobe0 cycle"}, 128'(s_cyc[0] - acc), 128'(1));
      chk({nm, " strobe0 addr"}, 128'(s_addr[0]), 128'(v.addr));
      chk({nm, " strobe0 mode"}, 128'(s_mode[0]), 128'((v.mode == 3'd5) ? 3'd4 : v.mode));
      if (v.wr) chk({nm, " strobe0 wrValue"}, 128'(s_val[0]), 128'(v.data[63:0]));
    end
    if (exp_n > 1) begin
      chk({nm, " strobe1 cycle"}, 128'(s_cyc[1] - acc), 128'(4));
      chk({nm, " strobe1 addr"}, 128'(s_addr[1]), 128'(v.addr + 48'd8));
      chk({nm, " strobe1 mode"}, 128'(s_mode[1]), 128'(3'd4));
      if (v.wr) chk({nm, " strobe1 wrValue"}, 128'(s_val[1]), 128'(v.data[127:64]));
    end
    if (hold > 0) begin
      bad = 0;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (rspValid !== 1'b1 || rspData !== v.rdata || rspFault !== v.fault || reqReady !== 1'b0)
          bad = 1;
      end
      chk({nm, " held response stable"}, 128'(bad), 128'(0));
      rspReady = 1'b1;
    end
    @(negedge clk);
    chk({nm, " rspValid after handshake"}, 128'(rspValid), 128'(0));
    chk({nm, " reqReady after handshake"}, 128'(reqReady), 128'(1));
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, " reqReady"}, 128'(reqReady), 128'(1));
    chk({nm, " rspValid"}, 128'(rspValid), 128'(0));
    chk({nm, " rspFault"}, 128'(rspFault), 128'(0));
    chk({nm, " rspData"}, rspData, 128'(0));
    chk({nm, " opRd"}, 128'(opRd), 128'(0));
    chk({nm, " opWr"}, 128'(opWr), 128'(0));
    chk({nm, " opMode"}, 128'(opMode), 128'(0));
    chk({nm, " memAddr"}, 128'(memAddr), 128'(0));
    chk({nm, " wrValue"}, 128'(wrValue), 128'(0));
  endtask

  vec_t vecs [16];
  vec_t v;
  int   acc;

  initial begin
    vecs[0]  = '{1'b0, 3'd3, 48'h10,          128'h0, 1'b0, 128'hFFFF_FFFF_8000_0001};
    vecs[1]  = '{1'b1, 3'd5, 48'h20,
                 128'h1111_1111_1111_1111_2222_2222_2222_2222, 1'b0, 128'h0};
    vecs[2]  = '{1'b0, 3'd4, 48'h20,          128'h0, 1'b0, 128'h2222_2222_2222_2222};
    vecs[3]  = '{1'b0, 3'd4, 48'h28,          128'h0, 1'b0, 128'h1111_1111_1111_1111};
    vecs[4]  = '{1'b0, 3'd5, 48'h20,          128'h0, 1'b0,
                 128'h1111_1111_1111_1111_2222_2222_2222_2222};
    vecs[5]  = '{1'b0, 3'd0, 48'h40,          128'h0, 1'b1, 128'h0};
    vecs[6]  = '{1'b0, 3'd4, 48'h22,          128'h0, 1'b1, 128'h0};
    vecs[7]  = '{1'b0, 3'd3, 48'h1_0000_0000, 128'h0, 1'b1, 128'h0};
    vecs[8]  = '{1'b0, 3'd1, 48'h3FFF,        128'h0, 1'b1, 128'h0};
    vecs[9]  = '{1'b1, 3'd5, 48'h3FF8,        128'h5, 1'b1, 128'h0};
    vecs[10] = '{1'b0, 3'd2, 48'h3FFE,        128'h0, 1'b1, 128'h0};
    vecs[11] = '{1'b1, 3'd1, 48'h5,           128'hCDAB, 1'b0, 128'h0};
    vecs[12] = '{1'b0, 3'd6, 48'h5,           128'h0, 1'b0, 128'hAB};
    vecs[13] = '{1'b0, 3'd1, 48'h5,           128'h0, 1'b0, 128'hFFFF_FFFF_FFFF_FFAB};
    vecs[14] = '{1'b0, 3'd4, 48'h3FF0,        128'h0, 1'b0, 128'h0};
    vecs[15] = '{1'b0, 3'd1, 48'h3FFE,        128'h0, 1'b0, 128'h0};

    nReset = 1'b0; reqValid = 1'b0; reqWr = 1'b0; reqMode = '0;
    reqAddr = '0; reqData = '0; rspReady = 1'b1; scnt = 0; rcnt = 0;
    repeat (2) @(negedge clk);
    chk_reset("reset");
    nReset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 16; i++) run(vecs[i], 0, $sformatf("vec%0d", i));

    // Response held off for 6 cycles.
    v = '{1'b0, 3'd3, 48'h10, 128'h0, 1'b0, 128'hFFFF_FFFF_8000_0001};
    run(v, 6, "backpressure");

    // Async reset during the phase-1 strobe of an OWORD store.
    scnt = 0; rcnt = 0;
    reqValid = 1'b1; reqWr = 1'b1; reqMode = 3'd5; reqAddr = 48'h30;
    reqData = 128'hAAAA_AAAA_AAAA_AAAA_5555_5555_5555_5555;
    @(negedge clk);
    reqValid = 1'b0;
    acc = cyc;
    while (cyc < acc + 4) @(negedge clk);
    chk("midreset opWr before", 128'(opWr), 128'(1));
    #1 nReset = 1'b0;
    #1 chk_reset("midreset");
    @(negedge clk);
    nReset = 1'b1;
    @(negedge clk);

    v = '{1'b0, 3'd4, 48'h30, 128'h0, 1'b0, 128'h5555_5555_5555_5555};
    run(v, 0, "post-reset low half");
    v = '{1'b0, 3'd4, 48'h38, 128'h0, 1'b0, 128'h0};
    run(v, 0, "post-reset high half");

    chk("strobe overlap", 128'(overlap), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_tile_seq.md
# mem_tile_seq

Request sequencer sitting directly upstream of the tile memory: accepts load/store requests from the CPU execute stage over a valid/ready handshake, range- and alignment-checks them, and drives the tile's level-sensitive opRd/opWr strobes with address, mode and data held stable around each strobe. 128-bit (OWORD) accesses are split into two 64-bit tile accesses. Results or faults return on a response channel with backpressure.

## Interface
- TILE_BITS, 14: log2 of tile size in bytes; tile word index = memAddr[TILE_BITS-1:2].
- TILE_BASE, 48'h0: tile base address; only bits [47:TILE_BITS] are compared.
- clk  in  1  clock; all state changes on rising edge.
- nReset  in  1  reset, asynchronous, active-low.
- reqValid  in  1  request present.
- reqReady  out  1  sequencer can accept; high only in IDLE.
- reqWr  in  1  1 = store, 0 = load.
- reqMode  in  3  0 NONE, 1 BYTE, 2 WORD, 3 DWORD, 4 QWORD, 5 OWORD, 6 UBYTE, 7 UWORD.
- reqAddr  in  48  byte address.
- reqData  in  128  store data; bits [63:0] used except OWORD.
- rspValid  out  1  response present; held until rspReady.
- rspReady  in  1  consumer accepts response.
- rspData  out  128  load result; 0 for stores and faults.
- rspFault  out  1  request rejected; no tile access performed.
- opRd  out  1  tile read strobe.
- opWr  out  1  tile write strobe.
- opMode  out  3  tile access mode (OWORD halves sent as 3'b100).
- memAddr  out  48  tile byte address.
- wrValue  out  64  tile write data.
- rdValue  in  64  tile read data, already extended per opMode.

## Operation
- States: IDLE, SETUP, STROBE, HOLD, RESP. Phase counter (0/1) tracks OWORD halves.
- IDLE: reqReady=1. On reqValid, latch wr/mode/addr/data, evaluate fault:
  - mode NONE; or reqAddr[47:TILE_BITS] != TILE_BASE[47:TILE_BITS];
  - QWORD/OWORD with reqAddr[1:0] != 0;
  - tile offset + size > 2^TILE_BITS (size 1/2/4/8/16; offset = reqAddr[TILE_BITS-1:0]).
  - Also fault if offset+size lands in the last word with a spill to word index 2^(TILE_BITS-2) (same condition as above; must not wrap to index 0).
  - Fault -> RESP with rspFault=1, rspData=0, no strobe. Else -> SETUP, phase 0.
- SETUP: drive memAddr = addr + 8*phase, opMode (OWORD->4), wrValue = phase ? data[127:64] : data[63:0]; strobes low.
- STROBE: opRd=!wr or opWr=wr, exactly one cycle; memAddr/opMode/wrValue unchanged.
- HOLD: strobes low, outputs unchanged; on loads capture rdValue into rspData[63:0] (phase 0) or [127:64] (phase 1) at end of cycle.
- After HOLD: OWORD phase 0 -> SETUP phase 1; otherwise RESP.
- Non-OWORD loads: rspData[127:64]=0.
- RESP: rspValid=1 until rspReady sampled high, then IDLE with rspValid=0. reqReady stays 0 in RESP.
- memAddr/opMode/wrValue keep last values outside SETUP..HOLD (no toggling in IDLE).
- opRd and opWr never high together; never high outside STROBE.

## Timing
- Reset (async assert, sync release edge): state IDLE, reqReady=1, rspValid=0, rspFault=0, rspData=0, opRd=0, opWr=0, opMode=0, memAddr=0, wrValue=0.
- Reset mid-operation: strobes drop immediately; OWORD store interrupted after phase 0 leaves only low half written (accepted behaviour).
- Accept at edge T: SETUP T+1, STROBE T+2, HOLD T+3, rspValid from T+4.
- OWORD: phase 1 SETUP T+4, STROBE T+5, HOLD T+6, rspValid from T+7.
- Fault: rspValid (rspFault=1) from T+1.
- rspReady high in first RESP cycle: IDLE next cycle; next accept one cycle after response handshake. Min spacing 5 cycles single, 8 OWORD, 2 fault.
- rspReady held low: rspValid, rspData, rspFault stable indefinitely.

## Test plan
- Reset, then DWORD load addr 0x10, tile word4=0x8000_0001 -> opRd pulse at T+2 with memAddr=0x10, rspData=0xFFFF_FFFF_8000_0001 at T+4, rspFault=0.
- OWORD store addr 0x20 data {0x1111..., 0x2222...} -> two opWr pulses (T+2, T+5), memAddr 0x20 then 0x28, wrValue low then high, opMode=4 both; rspValid T+7, rspData=0.
- Faults: mode 0; QWORD addr 0x22; addr 0x1_0000_0000 (base 0); BYTE at 0x3FFF with last-word spill; OWORD at 0x3FF8 -> rspFault=1 at T+1, no opRd/opWr ever.
- Backpressure: load completes with rspReady=0 for 6 cycles -> rspValid/rspData stable, reqReady=0; release -> IDLE next cycle, new request accepted.
- Async reset asserted during STROBE of OWORD phase 1 -> opWr low same cycle, all outputs at reset values, first post-reset request completes normally.
- Back-to-back BYTE store 0x5 0xAB then UBYTE load 0x5 -> store strobe then load returns 0x0000_0000_0000_00AB; opRd/opWr never overlap.
